seq_chunk_adder: RTL and testbench

- Parametrised multi-cycle adder/subtractor. Adds two WIDTH-bit operands by reusing one CHUNK-bit ripple-carry slice over WIDTH/CHUNK cycles, carrying between cycles in a flop.
- Generalises the team's fixed-width ripple adders: any width, add or subtract mode, signed-overflow flag, valid/ready handshakes on both sides.
- Sits between operand-producing datapath stages and result consumers where area matters more than latency.

---
 rtl/seq_chunk_adder_pkg.sv | 26 ++
 rtl/seq_chunk_adder_chunk_ripple_adder.sv | 26 ++
 rtl/seq_chunk_adder.sv | 134 +++++++++++++
 tb/tb_seq_chunk_adder.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_chunk_adder_pkg.sv
// Shared definitions for the multi-cycle chunked adder/subtractor:
// FSM state encoding and helpers that size the chunk index.
package seq_chunk_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of CHUNK-bit slices needed to cover a WIDTH-bit operand.
  function automatic int nchunk_of(input int width, input int chunk);
    return width / chunk;
  endfunction

  // Index register width; at least one bit even for a single chunk.
  function automatic int idx_width(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << w) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/seq_chunk_adder_chunk_ripple_adder.sv
// Combinational CHUNK-bit ripple-carry slice. Also exposes the carry into
// the top bit so the caller can derive signed overflow on the last slice.
module chunk_ripple_adder #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             c_in,
  output logic [CHUNK-1:0] sum,
  output logic             c_out,
  output logic             c_msb
);

  logic [CHUNK:0] carry;

  assign carry[0] = c_in;

  for (genvar gi = 0; gi < CHUNK; gi++) begin : g_fa
    assign sum[gi]       = a[gi] ^ b[gi] ^ carry[gi];
    assign carry[gi + 1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
  end

  assign c_out = carry[CHUNK];
  assign c_msb = carry[CHUNK-1];

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle WIDTH-bit adder/subtractor that reuses one CHUNK-bit ripple
// slice over WIDTH/CHUNK cycles, with the inter-slice carry kept in a flop.
module seq_chunk_adder
  import seq_chunk_adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int NCHUNK = nchunk_of(WIDTH, CHUNK);
  localparam int IDX_W  = idx_width(NCHUNK);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
    $error("seq_chunk_adder: WIDTH must be a positive multiple of CHUNK");
  end

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, b_reg, sum_reg, sum_next;
  logic             carry_reg;
  logic [IDX_W-1:0] idx_reg;
  logic             c_out_reg, ovf_reg;
  logic             accept;

  logic [CHUNK-1:0] a_slice [NCHUNK];
  logic [CHUNK-1:0] b_slice [NCHUNK];
  logic [CHUNK-1:0] slice_sum;
  logic             slice_c_out, slice_c_msb;

  // Split the captured operands into selectable slices.
  for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_slice
    assign a_slice[gi] = a_reg[gi*CHUNK +: CHUNK];
    assign b_slice[gi] = b_reg[gi*CHUNK +: CHUNK];
  end

  chunk_ripple_adder #(.CHUNK(CHUNK)) u_slice (
    .a     (a_slice[idx_reg]),
    .b     (b_slice[idx_reg]),
    .c_in  (carry_reg),
    .sum   (slice_sum),
    .c_out (slice_c_out),
    .c_msb (slice_c_msb)
  );

  assign accept = (state_reg == IDLE) && in_valid;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state and handshake decode.
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    unique case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = RUN;
      end
      RUN: begin
        if (idx_reg == LAST_IDX) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Result word: cleared at accept, one slice written per RUN cycle.
  always_comb begin
    sum_next = sum_reg;
    if (accept) begin
      sum_next = '0;
    end else if (state_reg == RUN) begin
      for (int i = 0; i < NCHUNK; i++) begin
        if (idx_reg == IDX_W'(i)) sum_next[i*CHUNK +: CHUNK] = slice_sum;
      end
    end
  end

  // Operand capture, carry chaining across cycles and final flag latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      idx_reg   <= '0;
      c_out_reg <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      sum_reg <= sum_next;
      if (accept) begin
        a_reg     <= a;
        b_reg     <= sub ? ~b : b;
        carry_reg <= sub ? 1'b1 : c_in;
        idx_reg   <= '0;
      end else if (state_reg == RUN) begin
        carry_reg <= slice_c_out;
        idx_reg   <= idx_reg + 1'b1;
        if (idx_reg == LAST_IDX) begin
          // Last slice holds the word MSB, so its carries give the full-width flags.
          c_out_reg <= slice_c_out;
          ovf_reg   <= slice_c_out ^ slice_c_msb;
          idx_reg   <= '0;
        end
      end
    end
  end

  assign sum   = sum_reg;
  assign c_out = c_out_reg;
  assign ovf   = ovf_reg;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Self-checking bench for seq_chunk_adder (WIDTH=32, CHUNK=8): directed
// operations with literal expectations plus a cycle-level reference model.
module tb_seq_chunk_adder;

  localparam int W      = 32;
  localparam int C      = 8;
  localparam int NCHUNK = W / C;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         c_in = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         c_out;
  logic         ovf;

  int tests  = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } res_t;

  res_t exp_q[$];

  seq_chunk_adder #(.WIDTH(W), .CHUNK(C)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired got running want finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
    tests++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %08h want %08h", name, got, want);
    end
  endtask

  // Reference result from plain integer arithmetic on the full word.
  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic ci, input logic s);
    res_t r;
    logic [W-1:0] yy;
    logic         cc;
    logic [W:0]   full;
    logic [W-1:0] low;
    yy   = s ? ~y : y;
    cc   = s ? 1'b1 : ci;
    full = {1'b0, x} + {1'b0, yy} + W'(cc);
    low  = {1'b0, x[W-2:0]} + {1'b0, yy[W-2:0]} + W'(cc);
    r.s  = full[W-1:0];
    r.co = full[W];
    r.ov = full[W] ^ low[W-1];
    return r;
  endfunction

  // Cycle-level compare: accept -> NCHUNK cycles -> result until handshake.
  initial begin
    bit   busy;
    int   k;
    res_t h;
    busy = 0;
    k    = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy = 0;
        k    = 0;
        exp_q.delete();
      end else begin
        chk("model_in_ready", W'(in_ready), W'(!busy));
        chk("model_out_valid", W'(out_valid), W'(busy && k >= NCHUNK));
        if (busy && k >= NCHUNK && exp_q.size() > 0) begin
          chk("model_sum", sum, exp_q[0].s);
          chk("model_c_out", W'(c_out), W'(exp_q[0].co));
          chk("model_ovf", W'(ovf), W'(exp_q[0].ov));
        end
        if (!busy) begin
          if (in_valid) begin
            busy = 1;
            k    = 0;
            exp_q.push_back(model(a, b, c_in, sub));
          end
        end else if (k >= NCHUNK && out_ready) begin
          busy = 0;
          h    = exp_q.pop_front();
        end else begin
          k++;
        end
      end
    end
  end

  // Present operands for exactly one edge (block is idle when called).
  task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic ci, input logic s);
    @(posedge clk); #1;
    a = x; b = y; c_in = ci; sub = s; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Count edges after the accept edge until out_valid appears.
  task automatic wait_result(output int cnt);
    cnt = 0;
    while (!out_valid && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    if (!out_valid) chk("result_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_op(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic ci, input logic s, input logic [W-1:0] es,
                        input logic eco, input logic eov);
    int cnt;
    start_op(x, y, ci, s);
    wait_result(cnt);
    chk({name, "_latency"}, W'(cnt), W'(NCHUNK));
    chk({name, "_sum"}, sum, es);
    chk({name, "_c_out"}, W'(c_out), W'(eco));
    chk({name, "_ovf"}, W'(ovf), W'(eov));
    @(posedge clk); #1;
    chk({name, "_valid_one_cycle"}, W'(out_valid), 32'd0);
    chk({name, "_ready_back"}, W'(in_ready), 32'd1);
    $display("[TB] %s a=%08h b=%08h c_in=%0d sub=%0d -> sum=%08h c_out=%0d ovf=%0d",
             name, x, y, ci, s, sum, c_out, ovf);
  endtask

  initial begin
    res_t r;
    int   cnt;
    logic [W-1:0] held_sum;
    logic         held_co, held_ov;

    // Pin the model against hand-computed values.
    r = model(32'h0083C3AE, 32'h000727AE, 1'b0, 1'b0);
    chk("pin_model_add", r.s, 32'h008AEB5C);
    r = model(32'h80000000, 32'h00000001, 1'b0, 1'b1);
    chk("pin_model_sub_ovf", {r.s[W-1:2], r.co, r.ov}, {30'h1FFFFFFF, 1'b1, 1'b1});

    // Reset state.
    #12;
    chk("reset_sum", sum, 32'd0);
    chk("reset_flags", {30'd0, c_out, ovf}, 32'd0);
    chk("reset_out_valid", W'(out_valid), 32'd0);
    chk("reset_in_ready", W'(in_ready), 32'd1);
    @(posedge clk); #2;
    rst_n = 1'b1;

    run_op("basic_add", 32'h0083C3AE, 32'h000727AE, 1'b0, 1'b0, 32'h008AEB5C, 1'b0, 1'b0);
    run_op("carry_chain", 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0);
    run_op("add_ovf", 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1);
    run_op("sub_ovf", 32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1);
    run_op("sub_borrow", 32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0);

    // Backpressure: hold the result while a second request waits.
    out_ready = 1'b0;
    start_op(32'h12345678, 32'h11111111, 1'b0, 1'b0);
    wait_result(cnt);
    chk("bp_latency", W'(cnt), W'(NCHUNK));
    held_sum = sum;
    held_co  = c_out;
    held_ov  = ovf;
    chk("bp_first_sum", held_sum, 32'h23456789);
    a = 32'hF0000000; b = 32'h20000000; c_in = 1'b0; sub = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("bp_sum_stable", sum, held_sum);
      chk("bp_flags_stable", {30'd0, c_out, ovf}, {30'd0, held_co, held_ov});
      chk("bp_in_ready_low", W'(in_ready), 32'd0);
      chk("bp_out_valid_held", W'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_released_valid", W'(out_valid), 32'd0);
    chk("bp_released_ready", W'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_result(cnt);
    chk("bp_second_latency", W'(cnt), W'(NCHUNK));
    chk("bp_second_sum", sum, 32'hD0000000);
    chk("bp_second_c_out", W'(c_out), 32'd1);
    chk("bp_second_ovf", W'(ovf), 32'd0);
    $display("[TB] backpressure second op sum=%08h c_out=%0d ovf=%0d", sum, c_out, ovf);
    @(posedge clk); #1;

    // Reset two cycles after accept aborts the operation.
    start_op(32'h11111111, 32'h22222222, 1'b0, 1'b0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_sum", sum, 32'd0);
    chk("rst_mid_flags", {30'd0, c_out, ovf}, 32'd0);
    chk("rst_mid_out_valid", W'(out_valid), 32'd0);
    chk("rst_mid_in_ready", W'(in_ready), 32'd1);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("rst_no_spurious_valid", W'(out_valid), 32'd0);
    end
    $display("[TB] mid-operation reset aborted cleanly");
    run_op("after_reset", 32'h00000001, 32'h00000002, 1'b0, 1'b0, 32'h00000003, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
